// File: rtl/ssio_sdr_in_deskew.sv
// ---------------------------------------------------------------------------
// ssio_sdr_in_deskew
//   Multi-lane deskew and alignment stage for source-synchronous SDR receive
//   data, clocked by the recovered capture clock. On align_req it hunts a
//   per-lane training word, measures inter-lane skew in whole cycles, and
//   programs per-lane delay lines so all lanes leave cycle-aligned.
//
// Ports
//   clk         capture clock
//   rst         synchronous, active-high reset
//   input_d     captured lane bits, one per lane per cycle
//   align_req   single-cycle pulse that starts training
//   output_q    deskewed lane bits (input_d delayed by 1+lane_delay per lane)
//   locked      alignment valid
//   busy        training in progress (SEARCH, WINDOW or APPLY)
//   skew_error  last training failed; sticky until next align_req or rst
//   lane_delay  applied delay per lane, lane i at [i*DW +: DW]
// ---------------------------------------------------------------------------
module ssio_sdr_in_deskew #(
   parameter int                     WIDTH          = 4,
   parameter int                     MAX_SKEW       = 7,
   parameter int                     PATTERN_LEN    = 8,
   parameter logic [PATTERN_LEN-1:0] TRAIN_PATTERN  = 8'hA7,
   parameter int                     SEARCH_TIMEOUT = 1024,
   parameter int                     DW             = $clog2(MAX_SKEW+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      input_d,
   input  logic                  align_req,
   output logic [WIDTH-1:0]      output_q,
   output logic                  locked,
   output logic                  busy,
   output logic                  skew_error,
   output logic [WIDTH*DW-1:0]   lane_delay
);

   // state  | meaning
   // IDLE   | not aligned, waiting for align_req
   // SEARCH | waiting for the first lane to show the training word
   // WINDOW | first hit seen; collecting the remaining lanes within MAX_SKEW
   // APPLY  | one cycle: program lane delays from measured offsets
   // LOCKED | delays applied, output_q aligned across lanes
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_WINDOW,
      ST_APPLY,
      ST_LOCKED
   } state_t;

   localparam int              TW        = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
   localparam logic [TW-1:0]   TCNT_LAST = TW'(SEARCH_TIMEOUT - 1);
   localparam logic [DW:0]     WIN_LAST  = (DW+1)'(MAX_SKEW);

   state_t                 state, state_nxt;

   logic [MAX_SKEW-1:0]    dly     [WIDTH];
   logic [MAX_SKEW:0]      tap     [WIDTH];
   logic [PATTERN_LEN-1:0] sr      [WIDTH];
   logic [DW-1:0]          offset  [WIDTH];
   logic [DW-1:0]          dly_sel [WIDTH];

   logic [WIDTH-1:0]       hit;
   logic [WIDTH-1:0]       seen;
   logic [WIDTH-1:0]       seen_nxt;
   logic [DW-1:0]          cnt;
   logic [DW-1:0]          cnt_p1;
   logic [TW-1:0]          tcnt;
   logic [DW-1:0]          max_off;
   logic                   tcnt_last;
   logic                   win_last;
   logic                   all_seen;

   // ---------------- datapath: delay lines and pattern detect --------------
   // tap[i][k] is input_d[i] delayed by k cycles; the output register adds
   // one more, giving a total latency of 1+lane_delay.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         tap[i] = {dly[i], input_d[i]};
         hit[i] = (sr[i] == TRAIN_PATTERN);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            dly[i] <= '0;
            sr[i]  <= '0;
         end
         output_q <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            dly[i]      <= tap[i][MAX_SKEW-1:0];
            sr[i]       <= {sr[i][PATTERN_LEN-2:0], input_d[i]};
            output_q[i] <= tap[i][dly_sel[i]];
         end
      end
   end

   // ---------------- training control --------------------------------------
   assign seen_nxt  = seen | hit;
   assign all_seen  = &seen_nxt;
   assign cnt_p1    = cnt + DW'(1);
   assign tcnt_last = (tcnt == TCNT_LAST);
   assign win_last  = ((DW+1)'(cnt) + (DW+1)'(1)) == WIN_LAST;

   always_comb begin
      max_off = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (offset[i] > max_off) max_off = offset[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_LOCKED: begin
            if (align_req) state_nxt = ST_SEARCH;
         end
         ST_SEARCH: begin
            // A hit in the final timeout cycle still wins over the timeout.
            if (|hit)           state_nxt = (&hit) ? ST_APPLY : ST_WINDOW;
            else if (tcnt_last) state_nxt = ST_IDLE;
         end
         ST_WINDOW: begin
            if (all_seen)      state_nxt = ST_APPLY;
            else if (win_last) state_nxt = ST_IDLE;
         end
         ST_APPLY: state_nxt = ST_LOCKED;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            offset[i]  <= '0;
            dly_sel[i] <= '0;
         end
         seen       <= '0;
         cnt        <= '0;
         tcnt       <= '0;
         skew_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_LOCKED: begin
               // lane delays are deliberately kept until APPLY so the
               // datapath keeps running on the old alignment while training
               if (align_req) begin
                  for (int i = 0; i < WIDTH; i++) offset[i] <= '0;
                  seen       <= '0;
                  cnt        <= '0;
                  tcnt       <= '0;
                  skew_error <= 1'b0;
               end
            end
            ST_SEARCH: begin
               if (|hit) begin
                  for (int i = 0; i < WIDTH; i++) begin
                     if (hit[i]) offset[i] <= '0;
                  end
                  seen <= hit;
                  cnt  <= '0;
               end else if (tcnt_last) begin
                  skew_error <= 1'b1;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            ST_WINDOW: begin
               cnt <= cnt_p1;
               for (int i = 0; i < WIDTH; i++) begin
                  if (hit[i] && !seen[i]) offset[i] <= cnt_p1;
               end
               seen <= seen_nxt;
               if (!all_seen && win_last) begin
                  skew_error <= 1'b1;
                  for (int i = 0; i < WIDTH; i++) dly_sel[i] <= '0;
               end
            end
            ST_APPLY: begin
               // the latest lane gets zero added delay, earlier lanes wait
               for (int i = 0; i < WIDTH; i++) dly_sel[i] <= max_off - offset[i];
            end
            default: ;
         endcase
      end
   end

   // ---------------- status outputs ----------------------------------------
   always_comb begin
      lane_delay = '0;
      for (int i = 0; i < WIDTH; i++) lane_delay[i*DW +: DW] = dly_sel[i];
   end

   assign locked = (state == ST_LOCKED);
   assign busy   = (state == ST_SEARCH) || (state == ST_WINDOW) || (state == ST_APPLY);

endmodule

// File: tb/tb_ssio_sdr_in_deskew.sv
module tb_ssio_sdr_in_deskew;

   localparam int WIDTH    = 4;
   localparam int MAX_SKEW = 7;
   localparam int PL       = 8;
   localparam int TMO      = 1024;
   localparam int DW       = 3;
   localparam int LDW      = WIDTH * DW;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] input_d;
   logic             align_req;
   logic [WIDTH-1:0] output_q;
   logic             locked;
   logic             busy;
   logic             skew_error;
   logic [LDW-1:0]   lane_delay;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [WIDTH-1:0] hist [32];
   int               skew  [WIDTH];
   int               exp_d [WIDTH];

   ssio_sdr_in_deskew #(
      .WIDTH(WIDTH), .MAX_SKEW(MAX_SKEW), .PATTERN_LEN(PL),
      .TRAIN_PATTERN(8'hA7), .SEARCH_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .input_d(input_d), .align_req(align_req),
      .output_q(output_q), .locked(locked), .busy(busy),
      .skew_error(skew_error), .lane_delay(lane_delay)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Record what was driven this cycle, then step one clock and sample
   // shortly after the active edge.
   task automatic tick();
      hist[cyc[4:0]] = input_d;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [LDW-1:0] pack_delays();
      logic [LDW-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH; i++) v[i*DW +: DW] = DW'(exp_d[i]);
      return v;
   endfunction

   // Lane i output now should be the bit driven 1+exp_d[i] cycles ago.
   task automatic check_q(input string tag);
      logic [WIDTH-1:0] e;
      logic [4:0]       idx;
      e = '0;
      for (int i = 0; i < WIDTH; i++) begin
         idx  = 5'(cyc - 1 - exp_d[i]);
         e[i] = hist[idx][i];
      end
      chk(tag, 32'(output_q), 32'(e));
   endtask

   // Pulse align_req, send the training word on each lane offset by skew[i],
   // optionally repeat lane0's word by overlap, optionally pulse align_req
   // again at relative cycle req_rel, then check the resulting alignment.
   task automatic train(input bit rep0, input int req_rel);
      int             maxs, mins, n;
      bit             ok;
      logic [PL-1:0]  pat;
      logic [PL-2:0]  rep_tail;
      logic [WIDTH-1:0] v;
      pat      = 8'hA7;
      rep_tail = 7'b0100111;
      maxs = skew[0];
      mins = skew[0];
      for (int i = 1; i < WIDTH; i++) begin
         if (skew[i] > maxs) maxs = skew[i];
         if (skew[i] < mins) mins = skew[i];
      end
      input_d   = '0;
      align_req = 1'b1;
      tick();
      align_req = 1'b0;
      chk("req_locked_drop", 32'(locked), 0);
      chk("req_busy", 32'(busy), 1);
      chk("req_err_clear", 32'(skew_error), 0);
      chk("req_delay_hold", 32'(lane_delay), 32'(pack_delays()));
      for (int r = 0; r <= maxs + PL + 1; r++) begin
         v = '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (r >= skew[i] && r < skew[i] + PL) v[i] = pat[PL-1-(r-skew[i])];
         end
         if (rep0 && r >= PL && r < 2*PL-1) v[0] = rep_tail[PL-2-(r-PL)];
         input_d   = v;
         align_req = (r == req_rel);
         tick();
      end
      align_req = 1'b0;
      input_d   = '0;
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      ok = (maxs - mins) <= MAX_SKEW;
      for (int i = 0; i < WIDTH; i++) exp_d[i] = ok ? (maxs - skew[i]) : 0;
      chk("train_busy_done", 32'(busy), 0);
      chk("train_lane_delay", 32'(lane_delay), 32'(pack_delays()));
      chk("train_locked", 32'(locked), 32'(ok));
      chk("train_skew_error", 32'(skew_error), 32'(!ok));
   endtask

   task automatic random_data(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         input_d = WIDTH'($urandom);
         tick();
         check_q("q_model");
      end
   endtask

   initial begin
      int n, cnt_f;
      logic busy_before;
      for (int k = 0; k < 32; k++) hist[k] = '0;
      for (int i = 0; i < WIDTH; i++) exp_d[i] = 0;

      // reset state
      rst = 1'b1; input_d = '1; align_req = 1'b0;
      tick(); tick(); tick();
      chk("rst_output_q", 32'(output_q), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_skew_error", 32'(skew_error), 0);
      chk("rst_lane_delay", 32'(lane_delay), 0);
      rst = 1'b0; input_d = '0;
      for (int k = 0; k < 10; k++) tick();

      // pass-through with zero delay
      input_d = 4'b1010;
      tick();
      chk("pass_q", 32'(output_q), 32'hA);
      chk("pass_locked", 32'(locked), 0);
      chk("pass_delay", 32'(lane_delay), 0);
      input_d = '0;
      tick();
      chk("pass_q_after", 32'(output_q), 0);

      // skew {0,2,5,1}: expected lane3..0 = {4,0,3,5}
      skew = '{0, 2, 5, 1};
      train(1'b0, -1);
      chk("skew0251_delay", 32'(lane_delay), 32'({3'd4, 3'd0, 3'd3, 3'd5}));
      cnt_f = 0;
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < WIDTH; i++) input_d[i] = (r == 2 + skew[i]);
         tick();
         check_q("marker_model");
         if (output_q == 4'hF) cnt_f++;
      end
      chk("marker_aligned", cnt_f, 1);

      // largest correctable skew, then one beyond
      skew = '{0, 0, 7, 0};
      train(1'b0, -1);
      chk("skew7_delay", 32'(lane_delay), 32'({3'd7, 3'd0, 3'd7, 3'd7}));
      random_data(10);
      skew = '{0, 0, 8, 0};
      train(1'b0, -1);
      chk("skew8_delay", 32'(lane_delay), 0);

      // search timeout
      input_d = '0; align_req = 1'b1;
      tick();
      align_req = 1'b0;
      chk("tmo_err_clear", 32'(skew_error), 0);
      chk("tmo_busy", 32'(busy), 1);
      n = 0; busy_before = 1'b0;
      while (!skew_error && n < TMO + 100) begin
         busy_before = busy;
         tick();
         n++;
      end
      chk("tmo_latency", n, TMO);
      chk("tmo_busy_before", 32'(busy_before), 1);
      chk("tmo_busy_fall", 32'(busy), 0);
      chk("tmo_locked", 32'(locked), 0);

      // second align_req clears the error; lands on delays {1,2,3,0}
      skew = '{2, 1, 0, 3};
      train(1'b0, -1);
      chk("d1230_delay", 32'(lane_delay), 32'({3'd0, 3'd3, 3'd2, 3'd1}));
      random_data(10);

      // retrain from LOCKED with zero skew
      skew = '{0, 0, 0, 0};
      train(1'b0, -1);
      chk("zero_skew_delay", 32'(lane_delay), 0);
      random_data(10);

      // lane0 repeats its word within the window; align_req during WINDOW
      skew = '{0, 3, 1, 7};
      train(1'b1, 10);
      chk("repeat_delay", 32'(lane_delay), 32'({3'd0, 3'd6, 3'd4, 3'd7}));
      random_data(10);

      // rst mid-WINDOW
      input_d = '0; align_req = 1'b1;
      tick();
      align_req = 1'b0;
      for (int r = 0; r < 10; r++) begin
         input_d = '0;
         if (r < PL) input_d[0] = (8'hA7 >> (PL-1-r)) & 1;
         if (r >= 5 && r < 5 + PL) input_d[3:1] = ((8'hA7 >> (PL-1-(r-5))) & 1) ? 3'b111 : 3'b000;
         tick();
      end
      chk("win_busy_before_rst", 32'(busy), 1);
      rst = 1'b1; input_d = 4'b1111;
      tick();
      rst = 1'b0; input_d = '0;
      chk("winrst_output_q", 32'(output_q), 0);
      chk("winrst_locked", 32'(locked), 0);
      chk("winrst_busy", 32'(busy), 0);
      chk("winrst_skew_error", 32'(skew_error), 0);
      chk("winrst_lane_delay", 32'(lane_delay), 0);
      for (int i = 0; i < WIDTH; i++) exp_d[i] = 0;
      for (int k = 0; k < 10; k++) tick();

      // randomized skews against the delay model
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < WIDTH; i++) skew[i] = int'($urandom_range(0, 9));
         train(1'b0, -1);
         random_data(16);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
